// File: rtl/ucie_ctl_phy_sb_msg_rx_fifo.sv
// PHY sideband RX buffer: queues sideband config words in a small FIFO and drains
// them onto the RDI pl_cfg channel under a multi-credit counter.
module ucie_ctl_phy_sb_msg_rx_fifo #(
  parameter int NC      = 32,
  parameter int DEPTH   = 4,
  parameter int CRD_MAX = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_sb_data_valid,
  input  logic [NC-1:0]                i_data_received_sb,
  input  logic                         i_rdi_lp_cfg_crd,
  input  logic                         i_clr_err,
  output logic                         o_rdi_pl_cfg_vld,
  output logic [NC-1:0]                o_rdi_pl_cfg,
  output logic [$clog2(DEPTH+1)-1:0]   o_fifo_level,
  output logic [$clog2(CRD_MAX+1)-1:0] o_crd_avail,
  output logic                         o_overflow,
  output logic                         o_crd_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(CRD_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_WAIT_CRD = 2'd2
  } state_t;

  logic [NC-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] level_q;
  logic [LW-1:0] level_d;
  logic [CW-1:0] credit_q;
  logic [CW-1:0] credit_d;
  state_t        state_q;
  state_t        state_d;
  logic          pop;
  logic          push_acc;
  logic          overflow_evt;
  logic          crd_err_evt;
  logic          crd_full;

  // A full FIFO still accepts a word when the head leaves on the same edge.
  always_comb begin
    pop          = (level_q != '0) && (credit_q != '0);
    push_acc     = i_sb_data_valid && ((level_q != LW'(DEPTH)) || pop);
    overflow_evt = i_sb_data_valid && !push_acc;
    crd_full     = (credit_q == CW'(CRD_MAX));
    crd_err_evt  = i_rdi_lp_cfg_crd && crd_full && !pop;

    level_d = level_q;
    if (push_acc && !pop) begin
      level_d = level_q + LW'(1);
    end else if (!push_acc && pop) begin
      level_d = level_q - LW'(1);
    end

    credit_d = credit_q;
    if (pop && !i_rdi_lp_cfg_crd) begin
      credit_d = credit_q - CW'(1);
    end else if (!pop && i_rdi_lp_cfg_crd && !crd_full) begin
      credit_d = credit_q + CW'(1);
    end
  end

  // Next state looks at post-edge occupancy/credit, so SEND tracks the pop condition exactly.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (level_d != '0 && credit_d != '0) begin
          state_d = ST_SEND;
        end else if (level_d != '0) begin
          state_d = ST_WAIT_CRD;
        end
      end
      ST_SEND: begin
        if (level_d == '0) begin
          state_d = ST_IDLE;
        end else if (credit_d == '0) begin
          state_d = ST_WAIT_CRD;
        end
      end
      ST_WAIT_CRD: begin
        if (credit_d != '0) begin
          state_d = ST_SEND;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      credit_q <= CW'(CRD_MAX);
      state_q  <= ST_IDLE;
    end else begin
      if (push_acc) begin
        mem[wr_ptr] <= i_data_received_sb;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      level_q  <= level_d;
      credit_q <= credit_d;
      state_q  <= state_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rdi_pl_cfg_vld <= 1'b0;
      o_rdi_pl_cfg     <= '0;
    end else begin
      o_rdi_pl_cfg_vld <= pop;
      o_rdi_pl_cfg     <= pop ? mem[rd_ptr] : '0;
    end
  end

  // Set wins over clear when both land on the same edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_overflow <= 1'b0;
      o_crd_err  <= 1'b0;
    end else begin
      o_overflow <= overflow_evt | (o_overflow & ~i_clr_err);
      o_crd_err  <= crd_err_evt  | (o_crd_err  & ~i_clr_err);
    end
  end

  assign o_fifo_level = level_q;
  assign o_crd_avail  = credit_q;

  a_send_matches_pop : assert property (
    @(posedge i_clk) disable iff (!i_rst_n) ((state_q == ST_SEND) == pop)
  );

endmodule

// File: tb/tb_ucie_ctl_phy_sb_msg_rx_fifo.sv
// Directed bench for the sideband RX FIFO: latency, credit stalls, overflow,
// credit-return errors and mid-operation reset, all with hand-computed expectations.
module tb_ucie_ctl_phy_sb_msg_rx_fifo;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_sb_data_valid;
  logic [31:0] i_data_received_sb;
  logic        i_rdi_lp_cfg_crd;
  logic        i_clr_err;
  logic        o_rdi_pl_cfg_vld;
  logic [31:0] o_rdi_pl_cfg;
  logic [2:0]  o_fifo_level;
  logic [2:0]  o_crd_avail;
  logic        o_overflow;
  logic        o_crd_err;

  int checks;
  int failures;

  ucie_ctl_phy_sb_msg_rx_fifo #(.NC(32), .DEPTH(4), .CRD_MAX(4)) dut (
    .i_clk              (i_clk),
    .i_rst_n            (i_rst_n),
    .i_sb_data_valid    (i_sb_data_valid),
    .i_data_received_sb (i_data_received_sb),
    .i_rdi_lp_cfg_crd   (i_rdi_lp_cfg_crd),
    .i_clr_err          (i_clr_err),
    .o_rdi_pl_cfg_vld   (o_rdi_pl_cfg_vld),
    .o_rdi_pl_cfg       (o_rdi_pl_cfg),
    .o_fifo_level       (o_fifo_level),
    .o_crd_avail        (o_crd_avail),
    .o_overflow         (o_overflow),
    .o_crd_err          (o_crd_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, then advance past the next rising edge.
  task automatic applyStimulus(input logic vld, input logic [31:0] data, input logic crd, input logic clr);
    i_sb_data_valid    = vld;
    i_data_received_sb = data;
    i_rdi_lp_cfg_crd   = crd;
    i_clr_err          = clr;
    @(posedge i_clk);
    #1;
  endtask

  task automatic checkOut(input string tag, input logic vld, input logic [31:0] data);
    checkOutput({tag, "_vld"}, 64'(o_rdi_pl_cfg_vld), 64'(vld));
    checkOutput({tag, "_data"}, 64'(o_rdi_pl_cfg), 64'(data));
  endtask

  logic [31:0] w [6];

  initial begin
    checks             = 0;
    failures           = 0;
    i_rst_n            = 1'b0;
    i_sb_data_valid    = 1'b0;
    i_data_received_sb = '0;
    i_rdi_lp_cfg_crd   = 1'b0;
    i_clr_err          = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    checkOutput("rst_vld", 64'(o_rdi_pl_cfg_vld), 64'd0);
    checkOutput("rst_data", 64'(o_rdi_pl_cfg), 64'd0);
    checkOutput("rst_level", 64'(o_fifo_level), 64'd0);
    checkOutput("rst_crd", 64'(o_crd_avail), 64'd4);
    checkOutput("rst_ovf", 64'(o_overflow), 64'd0);
    checkOutput("rst_crderr", 64'(o_crd_err), 64'd0);
    i_rst_n = 1'b1;

    // Single word: two-cycle latency.
    applyStimulus(1'b1, 32'hA5A5_0001, 1'b0, 1'b0);
    checkOutput("t1_level_e0", 64'(o_fifo_level), 64'd1);
    checkOut("t1_e0", 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOut("t1_e1", 1'b1, 32'hA5A5_0001);
    checkOutput("t1_crd", 64'(o_crd_avail), 64'd3);
    checkOutput("t1_level_e1", 64'(o_fifo_level), 64'd0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOut("t1_e2", 1'b0, 32'h0);
    checkOutput("t1_crd_back", 64'(o_crd_avail), 64'd4);
    checkOutput("t1_crderr", 64'(o_crd_err), 64'd0);

    // Six back-to-back words, four credits.
    for (int i = 0; i < 6; i++) w[i] = 32'h1111_0000 + 32'(i * 32'h0101);
    applyStimulus(1'b1, w[0], 1'b0, 1'b0);
    checkOut("t2_e0", 1'b0, 32'h0);
    for (int i = 1; i < 6; i++) begin
      applyStimulus(1'b1, w[i], 1'b0, 1'b0);
      if (i <= 4) checkOut($sformatf("t2_e%0d", i), 1'b1, w[i-1]);
      else        checkOut($sformatf("t2_e%0d", i), 1'b0, 32'h0);
    end
    checkOutput("t2_level", 64'(o_fifo_level), 64'd2);
    checkOutput("t2_crd", 64'(o_crd_avail), 64'd0);
    checkOutput("t2_state", 64'(dut.state_q), 64'd2);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOut("t2_ret1", 1'b0, 32'h0);
    checkOutput("t2_ret1_crd", 64'(o_crd_avail), 64'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOut("t2_rel1", 1'b1, w[4]);
    checkOutput("t2_rel1_level", 64'(o_fifo_level), 64'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOut("t2_hold", 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOut("t2_ret2", 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOut("t2_rel2", 1'b1, w[5]);
    checkOutput("t2_rel2_level", 64'(o_fifo_level), 64'd0);
    checkOutput("t2_rel2_crd", 64'(o_crd_avail), 64'd0);

    // Overflow at zero credit, then drain with credit returned alongside pops.
    for (int i = 0; i < 6; i++) w[i] = 32'hC0DE_0000 ^ 32'(32'h1000_0001 << i);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, w[i], 1'b0, 1'b0);
      checkOutput($sformatf("t3_lvl%0d", i), 64'(o_fifo_level), 64'(i < 4 ? i + 1 : 4));
    end
    checkOutput("t3_ovf", 64'(o_overflow), 64'd1);
    checkOut("t3_stall", 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("t3_ovf_clr", 64'(o_overflow), 64'd0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("t3_crd1", 64'(o_crd_avail), 64'd1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 32'h0, (i < 3) ? 1'b1 : 1'b0, 1'b0);
      checkOut($sformatf("t3_pop%0d", i), 1'b1, w[i]);
      checkOutput($sformatf("t3_pop%0d_crd", i), 64'(o_crd_avail), 64'(i < 3 ? 1 : 0));
    end
    checkOutput("t3_level_end", 64'(o_fifo_level), 64'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOut("t3_idle", 1'b0, 32'h0);

    // Credit return at full credit.
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("t5_crd4", 64'(o_crd_avail), 64'd4);
    checkOutput("t5_noerr", 64'(o_crd_err), 64'd0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("t5_crd_sat", 64'(o_crd_avail), 64'd4);
    checkOutput("t5_err", 64'(o_crd_err), 64'd1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("t5_setwins", 64'(o_crd_err), 64'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("t5_clr", 64'(o_crd_err), 64'd0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("t5_err2", 64'(o_crd_err), 64'd1);

    // Build up 3 buffered words at credit 1, then reset mid-cycle.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h5000_0000 + 32'(i), 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("t6_crd1", 64'(o_crd_avail), 64'd1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h6000_0000 + 32'(i), 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("t6_pre_level", 64'(o_fifo_level), 64'd3);
    checkOutput("t6_pre_crd", 64'(o_crd_avail), 64'd1);
    checkOutput("t6_pre_err", 64'(o_crd_err), 64'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    checkOut("t6_rst", 1'b0, 32'h0);
    checkOutput("t6_rst_level", 64'(o_fifo_level), 64'd0);
    checkOutput("t6_rst_crd", 64'(o_crd_avail), 64'd4);
    checkOutput("t6_rst_err", 64'(o_crd_err), 64'd0);
    checkOutput("t6_rst_ovf", 64'(o_overflow), 64'd0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    applyStimulus(1'b1, 32'hBEEF_0042, 1'b0, 1'b0);
    checkOut("t6_post_e0", 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOut("t6_post_e1", 1'b1, 32'hBEEF_0042);
    checkOutput("t6_post_crd", 64'(o_crd_avail), 64'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
